// File: rtl/frame_sequencer_pkg.sv
// Shared constants and state encodings for the Breakout frame controller,
// also used by the sync generator and colour engine.
package frame_sequencer_pkg;

    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned V_ACTIVE = 480;

    typedef enum logic [2:0] {
        ATTRACT   = 3'd0,
        SERVE     = 3'd1,
        PLAY      = 3'd2,
        GAME_OVER = 3'd3,
        WIN       = 3'd4
    } gameState_t;

    typedef enum logic [1:0] {
        WAIT_VB = 2'd0,
        PADDLE  = 2'd1,
        BALL    = 2'd2,
        COLL    = 2'd3
    } seqState_t;

endpackage

// File: rtl/frame_sequencer_if.sv
// Per-frame handshake bundle between the frame sequencer (master) and the
// game datapath units (slave).
interface frame_sequencer_if;

    logic       paddle_step;
    logic [1:0] paddle_dir;
    logic       ball_req;
    logic       ball_ack;
    logic       coll_req;
    logic       coll_ack;
    logic       miss;
    logic       cleared;
    logic       ball_reset;
    logic       bricks_reload;

    modport master (
        output paddle_step, paddle_dir, ball_req, coll_req, ball_reset, bricks_reload,
        input  ball_ack, coll_ack, miss, cleared
    );

    modport slave (
        input  paddle_step, paddle_dir, ball_req, coll_req, ball_reset, bricks_reload,
        output ball_ack, coll_ack, miss, cleared
    );

endinterface

// File: rtl/frame_sequencer_btn_sampler.sv
// Button synchroniser with once-per-frame sampling (frame-rate debounce)
// and rising-edge press detection.
module btn_sampler #(
    parameter int unsigned WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             frameTick,
    input  logic [WIDTH-1:0] rawBtn,
    output logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] press
);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
            level <= '0;
            press <= '0;
        end else begin
            sync1 <= rawBtn;
            sync2 <= sync1;
            // press is a one-cycle pulse in the cycle after the frame tick
            if (frameTick) begin
                level <= sync2;
                press <= sync2 & ~level;
            end else begin
                press <= '0;
            end
        end
    end

endmodule

// File: rtl/frame_sequencer.sv
// Breakout per-frame controller: detects vertical blanking, sequences the
// paddle/ball/collision datapath, and owns the game state and life counter.
module frame_sequencer
    import frame_sequencer_pkg::*;
#(
    parameter int unsigned LIVES_INIT   = 3,
    parameter int unsigned SERVE_FRAMES = 90,
    parameter int unsigned ACK_TIMEOUT  = 4095
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [9:0]        x_index,
    input  logic [9:0]        y_index,
    input  logic              left_btn,
    input  logic              right_btn,
    frame_sequencer_if.master dp,
    output logic [2:0]        game_state,
    output logic [1:0]        lives,
    output logic              seq_error
);

    localparam int unsigned SC_W = $clog2(SERVE_FRAMES + 1);
    localparam int unsigned TO_W = $clog2(ACK_TIMEOUT + 1);

    logic       frameTick;
    logic [1:0] btnLevel;
    logic [1:0] btnPress;
    logic       anyPress;

    gameState_t gameState, gameNext;
    logic [1:0] livesCount, livesNext;
    logic [SC_W-1:0] serveCount, serveNext;
    logic       ballResetQ, ballResetNext;
    logic       bricksReloadQ, bricksReloadNext;

    seqState_t  seqState, seqNext;
    logic [TO_W-1:0] waitCount, waitNext;
    logic       seqErrorQ, errSet;
    logic       collDone;
    logic       timeoutHit;

    assign frameTick = (y_index == 10'(V_ACTIVE)) && (x_index == '0);

    btn_sampler #(.WIDTH(2)) btnSamplerInst (
        .clk       (clk),
        .rst_n     (rst_n),
        .frameTick (frameTick),
        .rawBtn    ({left_btn, right_btn}),
        .level     (btnLevel),
        .press     (btnPress)
    );

    assign anyPress   = |btnPress;
    assign timeoutHit = (waitCount == TO_W'(ACK_TIMEOUT - 1));

    // Sequencer: req/step outputs decode directly from state so a reset drops them at once.
    always_comb begin
        seqNext  = seqState;
        waitNext = '0;
        errSet   = 1'b0;
        collDone = 1'b0;
        unique case (seqState)
            WAIT_VB: if (frameTick) seqNext = PADDLE;
            PADDLE:  seqNext = (gameState == PLAY) ? BALL : WAIT_VB;
            BALL: begin
                if (dp.ball_ack) begin
                    seqNext = COLL;
                end else if (timeoutHit) begin
                    seqNext = WAIT_VB;
                    errSet  = 1'b1;
                end else begin
                    waitNext = waitCount + TO_W'(1);
                end
            end
            COLL: begin
                if (dp.coll_ack) begin
                    seqNext  = WAIT_VB;
                    collDone = 1'b1;
                end else if (timeoutHit) begin
                    seqNext = WAIT_VB;
                    errSet  = 1'b1;
                end else begin
                    waitNext = waitCount + TO_W'(1);
                end
            end
            default: seqNext = WAIT_VB;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seqState  <= WAIT_VB;
            waitCount <= '0;
            seqErrorQ <= 1'b0;
        end else begin
            seqState  <= seqNext;
            waitCount <= waitNext;
            seqErrorQ <= seqErrorQ | errSet;
        end
    end

    always_comb begin
        gameNext         = gameState;
        livesNext        = livesCount;
        serveNext        = serveCount;
        ballResetNext    = 1'b0;
        bricksReloadNext = 1'b0;
        unique case (gameState)
            ATTRACT: begin
                if (anyPress) begin
                    gameNext         = SERVE;
                    livesNext        = 2'(LIVES_INIT);
                    serveNext        = '0;
                    ballResetNext    = 1'b1;
                    bricksReloadNext = 1'b1;
                end
            end
            SERVE: begin
                if (frameTick) serveNext = serveCount + SC_W'(1);
                if (anyPress || (serveCount >= SC_W'(SERVE_FRAMES))) gameNext = PLAY;
            end
            PLAY: begin
                if (collDone) begin
                    if (dp.cleared) begin
                        gameNext = WIN;
                    end else if (dp.miss) begin
                        if (livesCount <= 2'd1) begin
                            livesNext = '0;
                            gameNext  = GAME_OVER;
                        end else begin
                            livesNext     = livesCount - 2'd1;
                            ballResetNext = 1'b1;
                            serveNext     = '0;
                            gameNext      = SERVE;
                        end
                    end
                end
            end
            GAME_OVER, WIN: if (anyPress) gameNext = ATTRACT;
            default: gameNext = ATTRACT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gameState     <= ATTRACT;
            livesCount    <= 2'(LIVES_INIT);
            serveCount    <= '0;
            ballResetQ    <= 1'b0;
            bricksReloadQ <= 1'b0;
        end else begin
            gameState     <= gameNext;
            livesCount    <= livesNext;
            serveCount    <= serveNext;
            ballResetQ    <= ballResetNext;
            bricksReloadQ <= bricksReloadNext;
        end
    end

    assign dp.paddle_step   = (seqState == PADDLE) && ((gameState == SERVE) || (gameState == PLAY));
    assign dp.paddle_dir    = btnLevel;
    assign dp.ball_req      = (seqState == BALL);
    assign dp.coll_req      = (seqState == COLL);
    assign dp.ball_reset    = ballResetQ;
    assign dp.bricks_reload = bricksReloadQ;

    assign game_state = gameState;
    assign lives      = livesCount;
    assign seq_error  = seqErrorQ;

endmodule

// File: tb/tb_frame_sequencer.sv
// Frame-level bench for frame_sequencer: a datapath responder plus a
// per-frame game model predicting state, lives, pulses and handshakes.
module tb_frame_sequencer;
    import frame_sequencer_pkg::*;

    localparam int LIVES   = 3;
    localparam int SERVE_N = 90;
    localparam int TIMEOUT = 4095;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] x_index;
    logic [9:0] y_index;
    logic       left_btn;
    logic       right_btn;
    logic [2:0] game_state;
    logic [1:0] lives;
    logic       seq_error;

    frame_sequencer_if dp();

    frame_sequencer #(
        .LIVES_INIT   (LIVES),
        .SERVE_FRAMES (SERVE_N),
        .ACK_TIMEOUT  (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .x_index    (x_index),
        .y_index    (y_index),
        .left_btn   (left_btn),
        .right_btn  (right_btn),
        .dp         (dp),
        .game_state (game_state),
        .lives      (lives),
        .seq_error  (seq_error)
    );

    always #5 clk = ~clk;

    int testCount = 0;
    int failCount = 0;

    // Game model: 0 attract, 1 serve, 2 play, 3 game over, 4 win
    int       mState;
    int       mLives;
    int       mServe;
    bit       mErr;
    bit [1:0] mPrev;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testCount++;
        if (got !== exp) begin
            failCount++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic modelReset();
        mState = 0;
        mLives = LIVES;
        mServe = 0;
        mErr   = 1'b0;
        mPrev  = 2'b00;
    endtask

    // Random raster position that is never the start of vertical blanking
    task automatic driveIdle();
        x_index = 10'($urandom_range(0, 1023));
        y_index = 10'($urandom_range(0, 1023));
        if ($urandom_range(0, 3) == 0) y_index = 10'(V_ACTIVE);
        if (y_index == 10'(V_ACTIVE) && x_index == 10'd0) x_index = 10'd1;
    endtask

    task automatic runFrame(input bit l, input bit r, input int ballDly, input int collDly,
                            input bit missV, input bit clearedV, input bit overrun, input bit rstInColl);
        bit [1:0]   smp;
        bit         pressed, expStep, expHs, expColl, ballAckReal, collAckReal, tickSent;
        int         stAtTick, expReset, expReload, window;
        int         steps, resets, reloads, ballCycles, collCycles, ballCnt, collCnt;
        int         firstStep, firstBall, lastBall, firstColl;
        logic [1:0] dirSeen;

        smp      = {l, r};
        pressed  = |(smp & ~mPrev);
        mPrev    = smp;
        stAtTick = mState;
        if (mState == 1) mServe++;
        expStep   = (stAtTick == 1) || (stAtTick == 2);
        expHs     = (stAtTick == 2);
        expColl   = expHs && (ballDly < TIMEOUT);
        expReset  = 0;
        expReload = 0;
        case (mState)
            0: if (pressed) begin
                mState = 1; mLives = LIVES; mServe = 0; expReset = 1; expReload = 1;
            end
            1: if (pressed || mServe >= SERVE_N) mState = 2;
            3, 4: if (pressed) mState = 0;
            default: ;
        endcase
        if (expHs && !expColl) mErr = 1'b1;
        if (expColl) begin
            if (clearedV) mState = 4;
            else if (missV) begin
                if (mLives <= 1) begin mLives = 0; mState = 3; end
                else begin mLives--; expReset++; mState = 1; mServe = 0; end
            end
        end

        left_btn    = l;
        right_btn   = r;
        dp.ball_ack = 1'b0;
        dp.coll_ack = 1'b0;
        repeat (4) begin @(negedge clk); driveIdle(); end
        @(negedge clk);
        x_index = '0;
        y_index = 10'(V_ACTIVE);

        window = (ballDly >= TIMEOUT) ? TIMEOUT + 100 : ballDly + collDly + 12;
        steps = 0; resets = 0; reloads = 0; ballCycles = 0; collCycles = 0;
        ballCnt = 0; collCnt = 0; firstStep = -1; firstBall = -1; lastBall = -1; firstColl = -1;
        ballAckReal = 1'b0; collAckReal = 1'b0; tickSent = 1'b0; dirSeen = 2'b00;

        for (int cyc = 0; cyc < window; cyc++) begin
            @(negedge clk);
            if (dp.paddle_step) begin
                steps++; dirSeen = dp.paddle_dir;
                if (firstStep < 0) firstStep = cyc;
            end
            if (dp.ball_reset) resets++;
            if (dp.bricks_reload) reloads++;
            if (ballAckReal) checkVal("ball_req drop after ack", dp.ball_req, 0);
            if (collAckReal) checkVal("coll_req drop after ack", dp.coll_req, 0);
            if (dp.ball_req) begin
                ballCycles++; lastBall = cyc;
                if (firstBall < 0) firstBall = cyc;
            end
            if (dp.coll_req) begin
                collCycles++;
                if (firstColl < 0) firstColl = cyc;
            end
            if (rstInColl && collCycles == 3) begin
                rst_n = 1'b0;
                #1;
                checkVal("coll_req async reset", dp.coll_req, 0);
                checkVal("game_state async reset", game_state, 0);
                checkVal("lives async reset", lives, LIVES);
                break;
            end

            ballAckReal = 1'b0;
            collAckReal = 1'b0;
            dp.ball_ack = 1'b0;
            dp.coll_ack = 1'b0;
            dp.miss     = 1'($urandom_range(0, 1));
            dp.cleared  = 1'($urandom_range(0, 1));
            if (dp.ball_req) begin
                if (ballCnt == ballDly) begin dp.ball_ack = 1'b1; ballAckReal = 1'b1; end
                else ballCnt++;
            end else if ($urandom_range(0, 7) == 0) dp.ball_ack = 1'b1;
            if (dp.coll_req) begin
                if (collCnt == collDly) begin
                    dp.coll_ack = 1'b1; collAckReal = 1'b1;
                    dp.miss = missV; dp.cleared = clearedV;
                end else collCnt++;
            end else if ($urandom_range(0, 7) == 0) dp.coll_ack = 1'b1;
            driveIdle();
            if (overrun && !tickSent && dp.ball_req) begin
                x_index = '0; y_index = 10'(V_ACTIVE); tickSent = 1'b1;
            end
        end

        if (rstInColl) begin
            dp.ball_ack = 1'b0;
            dp.coll_ack = 1'b0;
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
            modelReset();
            checkVal("seq_error after reset", seq_error, 0);
            return;
        end

        checkVal("paddle_step count", steps, expStep);
        if (expStep) checkVal("paddle_dir", dirSeen, smp);
        checkVal("ball_req seen", ballCycles > 0, expHs);
        checkVal("coll_req seen", collCycles > 0, expColl);
        if (expHs) checkVal("ball_req length", ballCycles, expColl ? ballDly + 1 : TIMEOUT);
        if (expColl) begin
            checkVal("coll_req length", collCycles, collDly + 1);
            checkVal("step/ball/coll order",
                     (firstStep >= 0) && (firstBall > firstStep) && (firstColl > lastBall), 1);
        end
        checkVal("ball_reset count", resets, expReset);
        checkVal("bricks_reload count", reloads, expReload);
        checkVal("game_state", game_state, mState);
        checkVal("lives", lives, mLives);
        checkVal("seq_error", seq_error, mErr);
    endtask

    task automatic toPlay();
        for (int i = 0; i < 12 && mState != 2; i++) begin
            if (mPrev != 2'b00) runFrame(0, 0, 3, 3, 0, 0, 0, 0);
            else                runFrame(1, 0, 3, 3, 0, 0, 0, 0);
        end
        checkVal("reach PLAY", game_state, 2);
    endtask

    initial begin
        left_btn      = 1'b0;
        right_btn     = 1'b0;
        dp.ball_ack   = 1'b0;
        dp.coll_ack   = 1'b0;
        dp.miss       = 1'b0;
        dp.cleared    = 1'b0;
        x_index       = 10'd1;
        y_index       = 10'd0;
        modelReset();
        repeat (3) @(negedge clk);
        checkVal("reset game_state", game_state, 0);
        checkVal("reset lives", lives, LIVES);
        checkVal("reset seq_error", seq_error, 0);
        checkVal("reset ball_req", dp.ball_req, 0);
        checkVal("reset coll_req", dp.coll_req, 0);
        checkVal("reset paddle_step", dp.paddle_step, 0);
        checkVal("reset pulses", {dp.ball_reset, dp.bricks_reload}, 0);
        rst_n = 1'b1;

        repeat (2) runFrame(0, 0, 3, 3, 0, 0, 0, 0);
        repeat (2) runFrame(0, 1, 3, 3, 0, 0, 0, 0);
        checkVal("serve entered", game_state, 1);
        repeat (SERVE_N) runFrame(0, 0, 3, 3, 0, 0, 0, 0);
        checkVal("serve auto-launch", game_state, 2);
        repeat (3) runFrame(0, 0, 5, 5, 0, 0, 1, 0);

        for (int k = 0; k < 3; k++) begin
            toPlay();
            runFrame(0, 0, 5, 5, 1, 0, 0, 0);
        end
        checkVal("game over state", game_state, 3);
        checkVal("game over lives", lives, 0);

        toPlay();
        runFrame(0, 0, 4, 4, 1, 1, 0, 0);
        checkVal("win state", game_state, 4);
        checkVal("win lives", lives, LIVES);

        toPlay();
        runFrame(0, 0, 5000, 0, 0, 0, 0, 0);
        checkVal("timeout seq_error", seq_error, 1);
        runFrame(0, 0, 3, 3, 0, 0, 0, 0);
        runFrame(0, 0, 2, 100, 0, 0, 0, 1);

        for (int n = 0; n < 150; n++) begin
            runFrame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                     $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0,
                     $urandom_range(0, 4) == 0, 0);
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/frame_sequencer.md
Name: frame_sequencer

Overview:
- Per-frame game controller for the Breakout design, sitting between the VGA timing generator and the game datapath (paddle, ball, brick/collision logic feeding the colour engine).
- Detects start of vertical blanking and sequences one update step per datapath unit through req/ack handshakes.
- Owns the game-level state machine and the life counter.
- Samples and edge-detects the two buttons once per frame.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- V_ACTIVE, 480, visible lines per frame
- LIVES_INIT, 3, lives loaded on new game (max 3)
- SERVE_FRAMES, 90, frames held in SERVE before auto-launch
- ACK_TIMEOUT, 4095, max cycles waiting for any ack before abort

Ports:
- clk  in  1  system/pixel clock
- rst_n  in  1  asynchronous active-low reset
- x_index  in  10  current pixel column from sync generator
- y_index  in  10  current line from sync generator
- left_btn  in  1  raw left button
- right_btn  in  1  raw right button
- paddle_step  out  1  one-cycle pulse: move paddle one step
- paddle_dir  out  2  {left,right} sampled levels, valid with paddle_step
- ball_req  out  1  request ball position update; held until ball_ack
- ball_ack  in  1  ball update complete
- coll_req  out  1  request collision/brick evaluation; held until coll_ack
- coll_ack  in  1  collision complete; miss and cleared valid this cycle
- miss  in  1  ball passed below paddle
- cleared  in  1  no bricks remain
- ball_reset  out  1  one-cycle pulse: re-centre ball on paddle
- bricks_reload  out  1  one-cycle pulse: restore full brick wall
- game_state  out  3  current game state encoding
- lives  out  2  remaining lives
- seq_error  out  1  sticky: ack timeout occurred

Behaviour:
- Clock/reset: single clock clk; reset rst_n is asynchronous, active-low.
- Reset values: all pulses, req outputs and seq_error = 0; game_state = ATTRACT; lives = LIVES_INIT; sequencer state = WAIT_VB.
- Frame tick: one-cycle internal pulse when y_index == V_ACTIVE and x_index == 0. Exactly one tick per frame.
- Buttons: 2-flop synchroniser, then sampled only on frame tick. This gives 60 Hz debounce.
- Press event: sampled now AND NOT previous sample, for either button.
- Game FSM (ATTRACT=0, SERVE=1, PLAY=2, GAME_OVER=3, WIN=4):
  - ATTRACT: on press, load lives = LIVES_INIT, pulse bricks_reload and ball_reset, then go to SERVE.
  - SERVE: a frame counter counts ticks. On press or counter == SERVE_FRAMES, go to PLAY. Counter clears on SERVE entry.
  - PLAY: follows the collision result (see sequencer).
  - GAME_OVER / WIN: on press, go to ATTRACT.
- Sequencer FSM (WAIT_VB, PADDLE, BALL, COLL), runs on every frame tick:
  - WAIT_VB: on tick, go to PADDLE.
  - PADDLE: assert paddle_step for 1 cycle in SERVE and PLAY states, then go to BALL only if PLAY, else WAIT_VB.
  - BALL: ball_req = 1 until ball_ack is sampled high; ball_req drops the cycle after the ack; go to COLL.
  - COLL: coll_req = 1 until coll_ack. On the ack cycle, cleared takes priority over miss:
    - cleared: game_state goes to WIN.
    - else miss with lives == 1: lives = 0, go to GAME_OVER.
    - else miss: lives - 1, pulse ball_reset, go to SERVE.
    - Then return to WAIT_VB.
- Acks asserted while the matching req is low are ignored.
- Timeout: a cycle counter runs in BALL and COLL. At ACK_TIMEOUT, drop req, set seq_error (sticky until reset), go to WAIT_VB. Game state is unchanged.
- Overrun: a frame tick arriving while not in WAIT_VB is dropped. No restart, no queueing.
- Reset mid-handshake: req drops asynchronously; datapath must tolerate an abandoned req.
- Lives never wrap below 0.

Decomposition:
- Shared package / header:
  - game state encodings
  - H_ACTIVE / V_ACTIVE constants, also used by the sync generator and colour engine
- One sub-module: btn_sampler (synchroniser + frame-rate sample + press edge), instantiated once with 2-bit width.

Test Plan:
- Reset, then run 2 frames with no buttons -> game_state = 0, lives = 3, no paddle_step, no ball_req.
- Press right for 2 frames in ATTRACT -> exactly one bricks_reload and one ball_reset, game_state = 1. After 90 further ticks with no press -> game_state = 2.
- PLAY, ack after 5 cycles for ball and coll -> per tick: paddle_step 1 cycle, then ball_req, then coll_req, strictly ordered; a second tick during BALL is ignored.
- PLAY, lives = 3, coll_ack with miss = 1 -> lives = 2, ball_reset pulse, game_state = 1. Repeat until lives = 1 then miss -> lives = 0, game_state = 3.
- coll_ack with miss = 1 and cleared = 1 -> game_state = 4, lives unchanged.
- Withhold ball_ack -> ball_req drops after 4095 cycles, seq_error = 1. Next tick sequences normally. Assert rst_n low mid-coll_req -> coll_req = 0 immediately.
